// File: rtl/issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | issue_stage: in-order issue buffer with per-register pending scoreboard.   |
// | Optional build macro WB_BYPASS_EN lets a retiring writeback unblock issue. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module issue_stage #(
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 256,
  parameter int CNT_W     = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic                 in_src1_is_reg,
  input  logic                 in_src2_is_reg,
  input  logic                 in_need_to_wb,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rd,
  output logic                 out_src1_is_reg,
  output logic                 out_src2_is_reg,
  output logic                 out_need_to_wb,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 mem_stall,
  input  logic                 redirect_valid,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_rd,
  output logic [31:0]          busy_vec
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic                 src1_is_reg;
    logic                 src2_is_reg;
    logic                 need_to_wb;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];
  logic [CNT_W-1:0] pend_eff [32];

  entry_t      head;
  logic        push;
  logic        pop;
  logic        blocked;
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;

  assign head     = mem_q[head_q];
  assign in_ready = (count_q < DEPTH_C);

  // Pending view used only by the hazard check; the bypass build discounts a writer retiring this cycle.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      pend_eff[i] = pend_q[i];
`ifdef WB_BYPASS_EN
      if (wb_valid && (wb_rd == 5'(i)) && (pend_q[i] != '0)) begin
        pend_eff[i] = pend_q[i] - CNT_W'(1);
      end
`endif
    end
  end

  always_comb begin
    blocked = 1'b0;
    if (head.src1_is_reg && (head.rs1 != 5'd0) && (pend_eff[head.rs1] != '0)) blocked = 1'b1;
    if (head.src2_is_reg && (head.rs2 != 5'd0) && (pend_eff[head.rs2] != '0)) blocked = 1'b1;
    if (head.need_to_wb && (head.rd != 5'd0) && (pend_eff[head.rd] == CNT_MAX)) blocked = 1'b1;
  end

  assign out_valid       = (count_q != '0) && !blocked && !mem_stall && !redirect_valid;
  assign out_rs1         = head.rs1;
  assign out_rs2         = head.rs2;
  assign out_rd          = head.rd;
  assign out_src1_is_reg = head.src1_is_reg;
  assign out_src2_is_reg = head.src2_is_reg;
  assign out_need_to_wb  = head.need_to_wb;
  assign out_payload     = head.payload;

  always_comb begin
    push    = in_valid && in_ready && !redirect_valid;
    pop     = out_valid;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (redirect_valid) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                          src1_is_reg: in_src1_is_reg, src2_is_reg: in_src2_is_reg,
                          need_to_wb: in_need_to_wb, payload: in_payload};
        tail_d = tail_q + 1'b1;
      end
      if (pop) head_d = head_q + 1'b1;
      count_d = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  // x0 is never tracked: bit 0 of both vectors stays clear.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (pop && head.need_to_wb && (head.rd != 5'd0)) inc_vec = 32'd1 << head.rd;
    if (wb_valid && (wb_rd != 5'd0))                 dec_vec = 32'd1 << wb_rd;
    for (int i = 0; i < 32; i++) begin
      pend_d[i] = pend_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        pend_d[i] = pend_q[i] + CNT_W'(1);
      end else if (dec_vec[i] && !inc_vec[i] && (pend_q[i] != '0)) begin
        pend_d[i] = pend_q[i] - CNT_W'(1);
      end
    end
    pend_d[0] = '0;
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < 32; i++) busy_vec[i] = (pend_q[i] != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < 32; i++)    pend_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      for (int i = 0; i < 32; i++)    pend_q[i] <= pend_d[i];
    end
  end

`ifndef SYNTHESIS
  // A writeback with no writer in flight means the backend and scoreboard disagree.
  always_ff @(posedge clock) begin
    if (reset_n && wb_valid && (wb_rd != 5'd0)) begin
      assert (pend_q[wb_rd] != '0);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_issue_stage: directed vector table plus hand sequences for issue_stage. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_issue_stage;

  localparam int PAYLOAD_W = 256;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_rs1, in_rs2, in_rd;
  logic                 in_src1_is_reg, in_src2_is_reg, in_need_to_wb;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid;
  logic [4:0]           out_rs1, out_rs2, out_rd;
  logic                 out_src1_is_reg, out_src2_is_reg, out_need_to_wb;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 mem_stall, redirect_valid, wb_valid;
  logic [4:0]           wb_rd;
  logic [31:0]          busy_vec;

  int checks   = 0;
  int failures = 0;

  issue_stage #(.DEPTH(2), .PAYLOAD_W(PAYLOAD_W), .CNT_W(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_src1_is_reg(in_src1_is_reg), .in_src2_is_reg(in_src2_is_reg),
    .in_need_to_wb(in_need_to_wb), .in_payload(in_payload),
    .out_valid(out_valid), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_src1_is_reg(out_src1_is_reg), .out_src2_is_reg(out_src2_is_reg),
    .out_need_to_wb(out_need_to_wb), .out_payload(out_payload),
    .mem_stall(mem_stall), .redirect_valid(redirect_valid),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .busy_vec(busy_vec)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       iv;
    logic [4:0] rs1, rs2, rd;
    logic       s1, s2, wb;
    logic [7:0] tag;
    logic       stall, redir, wbv;
    logic [4:0] wbrd;
    logic       e_rdy, e_ov;
    logic [4:0] e_rd;
    logic [7:0] e_tag;
    logic [31:0] e_busy;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic s1, logic s2, logic wb, logic [7:0] tag,
                              logic stall, logic redir, logic wbv, logic [4:0] wbrd,
                              logic e_rdy, logic e_ov, logic [4:0] e_rd, logic [7:0] e_tag,
                              logic [31:0] e_busy);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.s1 = s1; v.s2 = s2; v.wb = wb;
    v.tag = tag; v.stall = stall; v.redir = redir; v.wbv = wbv; v.wbrd = wbrd;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_rd = e_rd; v.e_tag = e_tag; v.e_busy = e_busy;
    return v;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] pl(logic [7:0] tag);
    return {32{tag}};
  endfunction

  task automatic chk(string name, logic [PAYLOAD_W-1:0] act, logic [PAYLOAD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(logic iv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                       logic s1, logic s2, logic wb, logic [7:0] tag,
                       logic stall, logic redir, logic wbv, logic [4:0] wbrd);
    in_valid = iv; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_src1_is_reg = s1; in_src2_is_reg = s2; in_need_to_wb = wb; in_payload = pl(tag);
    mem_stall = stall; redirect_valid = redir; wb_valid = wbv; wb_rd = wbrd;
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    #1;
  endtask

  task automatic check_reset_state(string tagname);
    chk({tagname, "_in_ready"}, PAYLOAD_W'(in_ready), PAYLOAD_W'(1));
    chk({tagname, "_out_valid"}, PAYLOAD_W'(out_valid), PAYLOAD_W'(0));
    chk({tagname, "_out_rd"}, PAYLOAD_W'(out_rd), PAYLOAD_W'(0));
    chk({tagname, "_out_payload"}, out_payload, '0);
    chk({tagname, "_busy_vec"}, PAYLOAD_W'(busy_vec), PAYLOAD_W'(0));
  endtask

  vec_t tbl [27];

  initial begin
    // Rows are one cycle each; expectations are the outputs seen before that cycle's edge.
    tbl[0]  = mk(1, 0, 0, 5, 1, 0, 1, 8'h01, 0, 0, 0, 0,  1, 0, 0, 8'h00, 32'h0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  1, 1, 5, 8'h01, 32'h0);
    tbl[2]  = mk(1, 0, 0, 7, 0, 0, 1, 8'h02, 1, 0, 0, 0,  1, 0, 0, 8'h00, 32'h20);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 1, 8'h03, 1, 0, 0, 0,  1, 0, 0, 8'h00, 32'h20);
    tbl[4]  = mk(1, 0, 0, 9, 0, 0, 1, 8'h04, 1, 0, 0, 0,  0, 0, 0, 8'h00, 32'h20);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  0, 1, 7, 8'h02, 32'h20);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  1, 1, 0, 8'h03, 32'hA0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0,  1, 0, 0, 8'h00, 32'hA0);
    tbl[8]  = mk(1, 0, 0, 8, 0, 0, 1, 8'h05, 1, 0, 0, 0,  1, 0, 0, 8'h00, 32'hA0);
    tbl[9]  = mk(1, 0, 0, 8, 0, 0, 1, 8'h06, 1, 0, 0, 0,  1, 0, 0, 8'h00, 32'hA0);
    tbl[10] = mk(1, 0, 0,10, 0, 0, 1, 8'h07, 0, 1, 0, 0,  0, 0, 0, 8'h00, 32'hA0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 8'h00, 32'hA0);
    tbl[12] = mk(1, 0, 0,11, 0, 0, 1, 8'h08, 0, 1, 0, 0,  1, 0, 0, 8'h00, 32'hA0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 8'h00, 32'hA0);
    tbl[14] = mk(1, 0, 0, 7, 0, 0, 1, 8'h09, 0, 0, 0, 0,  1, 0, 0, 8'h00, 32'hA0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 7,  1, 1, 7, 8'h09, 32'hA0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 8'h00, 32'hA0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 7,  1, 0, 0, 8'h00, 32'hA0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 5,  1, 0, 0, 8'h00, 32'h20);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 8'h00, 32'h0);
    tbl[20] = mk(1, 0, 0, 3, 0, 0, 1, 8'h10, 0, 0, 0, 0,  1, 0, 0, 8'h00, 32'h0);
    tbl[21] = mk(1, 0, 0, 3, 0, 0, 1, 8'h11, 0, 0, 0, 0,  1, 1, 3, 8'h10, 32'h0);
    tbl[22] = mk(1, 0, 0, 3, 0, 0, 1, 8'h12, 0, 0, 0, 0,  1, 1, 3, 8'h11, 32'h08);
    tbl[23] = mk(1, 0, 0, 3, 0, 0, 1, 8'h13, 0, 0, 0, 0,  1, 1, 3, 8'h12, 32'h08);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 8'h00, 32'h08);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 3,  1, BYP, 3, 8'h13, 32'h08);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  1, !BYP, 3, 8'h13, 32'h08);

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_reset_state("reset");

    for (int i = 0; i < 27; i++) begin
      @(negedge clock);
      drive(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].s1, tbl[i].s2, tbl[i].wb,
            tbl[i].tag, tbl[i].stall, tbl[i].redir, tbl[i].wbv, tbl[i].wbrd);
      #1;
      chk($sformatf("row%0d_in_ready", i), PAYLOAD_W'(in_ready), PAYLOAD_W'(tbl[i].e_rdy));
      chk($sformatf("row%0d_out_valid", i), PAYLOAD_W'(out_valid), PAYLOAD_W'(tbl[i].e_ov));
      chk($sformatf("row%0d_busy_vec", i), PAYLOAD_W'(busy_vec), PAYLOAD_W'(tbl[i].e_busy));
      if (tbl[i].e_ov) begin
        chk($sformatf("row%0d_out_rd", i), PAYLOAD_W'(out_rd), PAYLOAD_W'(tbl[i].e_rd));
        chk($sformatf("row%0d_out_payload", i), out_payload, pl(tbl[i].e_tag));
      end
    end

    // Reset asserted mid-operation with busy inputs must still clear everything.
    @(negedge clock);
    reset_n = 1'b0;
    drive(1, 1, 2, 4, 1, 1, 1, 8'hEE, 0, 0, 1, 3);
    @(negedge clock);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    #1;
    check_reset_state("midreset");
    idle_cycle();
    chk("midreset_push_dropped", PAYLOAD_W'(out_valid), PAYLOAD_W'(0));

    // RAW dependency: add x6,x5,x5 waits for the x5 writeback.
    @(negedge clock);
    drive(1, 0, 0, 5, 1, 0, 1, 8'h21, 0, 0, 0, 0);
    idle_cycle();
    chk("raw_producer_valid", PAYLOAD_W'(out_valid), PAYLOAD_W'(1));
    @(negedge clock);
    drive(1, 5, 5, 6, 1, 1, 1, 8'h22, 0, 0, 0, 0);
    #1;
    chk("raw_busy_after_issue", PAYLOAD_W'(busy_vec), PAYLOAD_W'(32'h20));
    idle_cycle();
    chk("raw_blocked_valid", PAYLOAD_W'(out_valid), PAYLOAD_W'(0));
    chk("raw_blocked_head_rd", PAYLOAD_W'(out_rd), PAYLOAD_W'(6));
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 5);
    #1;
    chk("raw_wb_cycle_valid", PAYLOAD_W'(out_valid), PAYLOAD_W'(BYP));
    idle_cycle();
    chk("raw_after_wb_valid", PAYLOAD_W'(out_valid), PAYLOAD_W'(!BYP));
    idle_cycle();
    chk("raw_consumer_busy", PAYLOAD_W'(busy_vec), PAYLOAD_W'(32'h40));
    chk("raw_drained_valid", PAYLOAD_W'(out_valid), PAYLOAD_W'(0));
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 6);
    idle_cycle();
    chk("raw_final_busy", PAYLOAD_W'(busy_vec), PAYLOAD_W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
